// File: rtl/d_ff.sv
// d_ff: WIDTH-bit edge-triggered D register with asynchronous active-high reset to RST_VAL.
// Optional complementary output qn is enabled by defining D_FF_QN_EN.
module d_ff #(
   parameter int unsigned          WIDTH   = 1,
   parameter logic [WIDTH-1:0]     RST_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
`ifdef D_FF_QN_EN
   ,
   output logic [WIDTH-1:0] qn
`endif
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   assign q_d = d;

   // A clock edge seen while rst is still high keeps RST_VAL, so reset wins a coincident release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= RST_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

`ifdef D_FF_QN_EN
   // Derived from the same register; no second flop.
   assign qn = ~q_q;
`endif

endmodule

// File: tb/tb_d_ff.sv
// tb_d_ff: checks the 1-bit default d_ff against a timed sequence and an 8-bit
// d_ff (RST_VAL=8'hA5) against a vector table plus random data through an expected queue.
module tb_d_ff;

  logic       clk;
  logic       rst1;
  logic [0:0] d1;
  logic [0:0] q1;
  logic       rst8;
  logic [7:0] d8;
  logic [7:0] q8;
`ifdef D_FF_QN_EN
  logic [0:0] qn1;
  logic [7:0] qn8;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic       rst;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    #0;
    forever begin
      clk = 1'b1;
      #10;
      clk = 1'b0;
      #10;
    end
  end

  // ---------------- DUTs ----------------
  d_ff u_dut1 (
    .clk (clk),
    .rst (rst1),
    .d   (d1),
`ifdef D_FF_QN_EN
    .qn  (qn1),
`endif
    .q   (q1)
  );

  d_ff #(.WIDTH(8), .RST_VAL(8'hA5)) u_dut8 (
    .clk (clk),
    .rst (rst8),
    .d   (d8),
`ifdef D_FF_QN_EN
    .qn  (qn8),
`endif
    .q   (q8)
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic wait_until(input time t);
    if (t > $time) #(t - $time);
  endtask

  task automatic drive8(input logic r, input logic [7:0] dv, input logic [7:0] exp);
    @(negedge clk);
    rst8 = r;
    d8   = dv;
    exp_q.push_back(exp);
  endtask

  task automatic score8(input string name);
    logic [7:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk_cnt++;
      $display("FAIL %s: got %h expected queue entry, queue empty", name, q8);
    end else begin
      e = exp_q.pop_front();
      check(name, q8, e);
`ifdef D_FF_QN_EN
      check({name, "_qn"}, qn8, ~e);
`endif
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vecs[0] = '{rst: 1'b1, d: 8'h3C, exp: 8'hA5};
    vecs[1] = '{rst: 1'b0, d: 8'h3C, exp: 8'h3C};
    vecs[2] = '{rst: 1'b0, d: 8'hFF, exp: 8'hFF};
    vecs[3] = '{rst: 1'b0, d: 8'h00, exp: 8'h00};
    vecs[4] = '{rst: 1'b1, d: 8'h5A, exp: 8'hA5};
    vecs[5] = '{rst: 1'b1, d: 8'hC3, exp: 8'hA5};
    vecs[6] = '{rst: 1'b0, d: 8'h5A, exp: 8'h5A};
    vecs[7] = '{rst: 1'b0, d: 8'h81, exp: 8'h81};

    rst1 = 1'b1;
    d1   = 1'b0;
    rst8 = 1'b1;
    d8   = 8'h00;

    // Reset hold on the 1-bit flop, with d toggling underneath.
    wait_until(1);
    check("reset_q1", {7'd0, q1}, 8'h00);
    check("reset_q8", q8, 8'hA5);
`ifdef D_FF_QN_EN
    check("reset_qn8", qn8, 8'h5A);
`endif
    wait_until(50);
    d1 = 1'b1;
    wait_until(51);
    check("reset_hold_d1", {7'd0, q1}, 8'h00);
    wait_until(99);
    check("reset_hold_late", {7'd0, q1}, 8'h00);

    // Release and capture.
    wait_until(100);
    rst1 = 1'b0;
    d1   = 1'b1;
    wait_until(141);
    check("release_capture", {7'd0, q1}, 8'h01);
    wait_until(199);
    check("hold_one", {7'd0, q1}, 8'h01);

    // Data follow and mid-cycle stability.
    wait_until(200);
    d1 = 1'b0;
    wait_until(221);
    check("follow_zero", {7'd0, q1}, 8'h00);
    wait_until(225);
    d1 = 1'b1;
    wait_until(239);
    check("midcycle_stable", {7'd0, q1}, 8'h00);
    wait_until(241);
    check("capture_one", {7'd0, q1}, 8'h01);

    // Async reset pulse between edges.
    wait_until(253);
    rst1 = 1'b1;
    wait_until(254);
    check("async_reset", {7'd0, q1}, 8'h00);
    wait_until(257);
    rst1 = 1'b0;
    wait_until(259);
    check("after_pulse", {7'd0, q1}, 8'h00);
    wait_until(261);
    check("recapture", {7'd0, q1}, 8'h01);

    // Reset released exactly on a rising edge: reset wins that edge.
    wait_until(265);
    rst1 = 1'b1;
    d1   = 1'b1;
    @(posedge clk);
    rst1 <= 1'b0;
    #1;
    check("coincident_edge", {7'd0, q1}, 8'h00);
    @(posedge clk);
    #1;
    check("coincident_next", {7'd0, q1}, 8'h01);

    // 8-bit vector table through the expected queue.
    for (int i = 0; i < 8; i++) begin
      drive8(vecs[i].rst, vecs[i].d, vecs[i].exp);
      score8($sformatf("vec%0d", i));
    end

    // Async assert on the 8-bit flop between edges.
    @(negedge clk);
    #3;
    rst8 = 1'b1;
    #1;
    check("async_reset8", q8, 8'hA5);

    // Random data after release.
    for (int i = 0; i < 16; i++) begin
      logic [7:0] r;
      r = 8'($urandom_range(0, 255));
      drive8(1'b0, r, r);
      score8($sformatf("rand%0d", i));
    end

    if (exp_q.size() != 0) begin
      chk_cnt++;
      $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt + 1);
    $fatal(1);
  end

endmodule
